elastic_pipe: RTL and testbench
===============================

ELASTIC_PIPE -- requirements
Module: elastic_pipe

Interface
REQ-001 Parameter WIDTH, 4, data width in bits (>=1).
REQ-002 Parameter DEPTH, 2, number of register stages (>=1).
REQ-003 Parameter RESET_VAL, 0 (WIDTH bits), value loaded into every data stage by reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous discard of all held entries.
REQ-007 in_valid  input  1  upstream has a word on in_data.
REQ-008 in_ready  output  1  pipe accepts in_data this cycle.
REQ-009 in_data  input  WIDTH  upstream word.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  WIDTH  word in last stage.
REQ-013 count  output  $clog2(DEPTH+1)  number of valid stages, registered.

Function
REQ-014 The block SHALL hold DEPTH stages, each a WIDTH-bit data register plus a valid bit v[i]; stage 0 is the input end and stage DEPTH-1 the output end.
REQ-015 Stage enable SHALL be en[DEPTH-1] = ~v[DEPTH-1] | out_ready, and en[i] = ~v[i] | en[i+1] for i < DEPTH-1 (bubbles collapse; full throughput).
REQ-016 in_ready SHALL equal en[0] & ~flush, combinationally.
REQ-017 out_valid SHALL equal v[DEPTH-1] & ~flush; out_data SHALL equal stage DEPTH-1 data at all times.
REQ-018 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-019 When en[i], v[i] SHALL load the valid of the preceding stage (in_valid for stage 0); otherwise v[i] holds.
REQ-020 A data register SHALL load only when its stage is enabled and the preceding valid is 1; it SHALL otherwise hold, including when a bubble moves in.
REQ-021 Latency with no backpressure: a word accepted at edge N SHALL appear on out_data with out_valid=1 after edge N+DEPTH-1 (visible in the cycle following edge N+DEPTH-1), sustaining one word per cycle.
REQ-022 Order SHALL be preserved; no word is duplicated or dropped except by flush or reset.
REQ-023 Full (all v=1) with out_ready=0: in_ready SHALL be 0 and all stages hold.
REQ-024 Full with out_ready=1 and in_valid=1: push and pop SHALL occur in the same cycle; count unchanged.
REQ-025 count SHALL update as count + in - out each edge and SHALL always equal the number of set v[i]; range 0..DEPTH, no wrap.
REQ-026 flush=1 SHALL clear all v[i] and count to 0 at the next edge; no transfer completes in a flush cycle; data registers hold.
REQ-027 reset SHALL take priority over flush and all transfers.

Reset
REQ-028 On reset at an edge: all v[i]=0, all data stages=RESET_VAL, count=0.
REQ-029 In the cycle after reset: out_valid=0, out_data=RESET_VAL, in_ready=1 (if flush=0), count=0.
REQ-030 Reset asserted mid-stream SHALL discard all entries regardless of in_valid/out_ready; no word accepted during a reset cycle is retained.

Verification (WIDTH=4, DEPTH=2, RESET_VAL=0)
REQ-031 Reset 1 cycle, then idle -> out_valid=0, out_data=4'h0, count=0, in_ready=1.
REQ-032 out_ready=1, push 1,2,3 on consecutive edges -> out_data 1,2,3 on consecutive cycles, first visible one cycle after accepting 1; count peaks at 2.
REQ-033 out_ready=0, in_valid=1 with A,B,C -> A,B accepted, in_ready=0 on C, count=2; raise out_ready -> A, B, C delivered in order.
REQ-034 Full, out_ready=1, in_valid=1 with D -> in_ready=1, oldest word pops, D enters, count stays 2.
REQ-035 Push A, idle one cycle with out_ready=0 -> A collapses to stage 1, count=1, in_ready=1; push B -> count=2.
REQ-036 Full, assert flush one cycle with in_valid=1 -> in_ready=0 and out_valid=0 that cycle, then count=0, out_valid=0; repeat with reset instead of flush -> data stages read 4'h0.

Source files
------------

// File: rtl/elastic_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages whose bubbles collapse,
// so the pipe sustains one word per cycle and stalls only when every stage is full.
module elastic_pipe #(
  parameter int unsigned           WIDTH     = 4,
  parameter int unsigned           DEPTH     = 2,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0,
  localparam int unsigned          CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [CW-1:0]    count_q;

  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0] prev_v;
  logic [WIDTH-1:0] prev_d [DEPTH];
  logic             carry;
  logic             push;
  logic             pop;

  // A stage may advance when it is empty or when the stage after it advances.
  always_comb begin
    en    = '0;
    carry = ~v_q[DEPTH-1] | out_ready;
    en[DEPTH-1] = carry;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      carry = ~v_q[i] | carry;
      en[i] = carry;
    end
  end

  always_comb begin
    prev_v    = '0;
    prev_v[0] = in_valid;
    prev_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      prev_v[i] = v_q[i-1];
      prev_d[i] = data_q[i-1];
    end
  end

  assign in_ready  = en[0] & ~flush;
  assign out_valid = v_q[DEPTH-1] & ~flush;
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Data registers keep their old contents when a bubble moves in, so
  // out_data keeps showing the last word that reached the output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
    end else if (flush) begin
      v_q     <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (en[i]) v_q[i] <= prev_v[i];
        if (en[i] && prev_v[i]) data_q[i] <= prev_d[i];
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: directed vector table for the documented scenarios,
// then random traffic checked against a queue-based occupancy model.
module tb_elastic_pipe;
  localparam int W = 4;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int errors = 0;
  int checks = 0;

  elastic_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(4'h0)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst, fl, iv;
    logic [W-1:0] d;
    logic         ordy, chk, eir, eov;
    logic [W-1:0] eod;
    logic [1:0]   ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, fl, iv, input logic [W-1:0] d, input logic ordy,
                     input logic chk, eir, eov, input logic [W-1:0] eod, input logic [1:0] ecnt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.chk = chk; v.eir = eir; v.eov = eov; v.eod = eod; v.ecnt = ecnt;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of words in arrival order, each with a stage position.
  logic [W-1:0] m_data[$];
  int           m_pos[$];
  logic [W-1:0] m_last;

  function automatic logic m_in_ready(input logic fl, input logic ordy);
    return !fl && (m_data.size() < D || ordy);
  endfunction

  function automatic logic m_out_valid(input logic fl);
    return !fl && m_data.size() > 0 && m_pos[0] == D - 1;
  endfunction

  task automatic m_step(input logic rst, fl, iv, input logic [W-1:0] d, input logic ordy);
    int limit;
    logic do_push;
    if (rst) begin
      m_data.delete(); m_pos.delete(); m_last = '0;
    end else if (fl) begin
      m_data.delete(); m_pos.delete();
    end else begin
      do_push = iv && m_in_ready(fl, ordy);
      if (m_out_valid(fl) && ordy) begin
        void'(m_data.pop_front()); void'(m_pos.pop_front());
      end
      limit = D - 1;
      foreach (m_pos[i]) begin
        m_pos[i] = (m_pos[i] + 1 < limit) ? m_pos[i] + 1 : limit;
        limit = m_pos[i] - 1;
        if (m_pos[i] == D - 1) m_last = m_data[i];
      end
      if (do_push) begin
        m_data.push_back(d); m_pos.push_back(0);
        if (D == 1) m_last = d;
      end
    end
  endtask

  task automatic drive(input logic rst, fl, iv, input logic [W-1:0] d, input logic ordy);
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);

    //   rst fl iv d     ordy chk ir ov od    cnt
    add(1, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0);
    add(0, 0, 0, 4'h0, 0, 1, 1, 0, 4'h0, 0);   // idle after reset
    add(0, 0, 1, 4'h1, 1, 1, 1, 0, 4'h0, 0);   // stream 1,2,3
    add(0, 0, 1, 4'h2, 1, 1, 1, 0, 4'h0, 1);
    add(0, 0, 1, 4'h3, 1, 1, 1, 1, 4'h1, 2);
    add(0, 0, 0, 4'h0, 1, 1, 1, 1, 4'h2, 2);
    add(0, 0, 0, 4'h0, 1, 1, 1, 1, 4'h3, 1);
    add(0, 0, 0, 4'h0, 0, 1, 1, 0, 4'h3, 0);
    add(0, 0, 1, 4'hA, 0, 1, 1, 0, 4'h3, 0);   // backpressure A,B,C
    add(0, 0, 1, 4'hB, 0, 1, 1, 0, 4'h3, 1);
    add(0, 0, 1, 4'hC, 0, 1, 0, 1, 4'hA, 2);
    add(0, 0, 1, 4'hC, 1, 1, 1, 1, 4'hA, 2);
    add(0, 0, 0, 4'h0, 1, 1, 1, 1, 4'hB, 2);
    add(0, 0, 0, 4'h0, 1, 1, 1, 1, 4'hC, 1);
    add(0, 0, 1, 4'h4, 0, 1, 1, 0, 4'hC, 0);   // fill, then push+pop while full
    add(0, 0, 1, 4'h5, 0, 1, 1, 0, 4'hC, 1);
    add(0, 0, 1, 4'hD, 1, 1, 1, 1, 4'h4, 2);
    add(0, 0, 0, 4'h0, 0, 1, 0, 1, 4'h5, 2);
    add(0, 0, 0, 4'h0, 1, 1, 1, 1, 4'h5, 2);
    add(0, 0, 0, 4'h0, 1, 1, 1, 1, 4'hD, 1);
    add(0, 0, 1, 4'h6, 0, 1, 1, 0, 4'hD, 0);   // bubble collapse
    add(0, 0, 0, 4'h0, 0, 1, 1, 0, 4'hD, 1);
    add(0, 0, 1, 4'h7, 0, 1, 1, 1, 4'h6, 1);
    add(0, 0, 0, 4'h0, 0, 1, 0, 1, 4'h6, 2);
    add(0, 1, 1, 4'h8, 0, 1, 0, 0, 4'h6, 2);   // flush while full
    add(0, 0, 0, 4'h0, 0, 1, 1, 0, 4'h6, 0);
    add(0, 0, 1, 4'h9, 0, 1, 1, 0, 4'h6, 0);
    add(0, 0, 1, 4'hB, 0, 1, 1, 0, 4'h6, 1);
    add(0, 1, 0, 4'h0, 1, 1, 0, 0, 4'h9, 2);   // flush blocks transfers even with out_ready
    add(0, 0, 1, 4'h9, 0, 1, 1, 0, 4'h9, 0);
    add(0, 0, 1, 4'hB, 0, 1, 1, 0, 4'h9, 1);
    add(1, 0, 1, 4'hE, 1, 1, 1, 1, 4'h9, 2);   // reset while full
    add(0, 0, 0, 4'h0, 0, 1, 1, 0, 4'h0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      @(negedge clk);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d in_ready", i), int'(in_ready), int'(tbl[i].eir));
        check($sformatf("vec%0d out_valid", i), int'(out_valid), int'(tbl[i].eov));
        check($sformatf("vec%0d out_data", i), int'(out_data), int'(tbl[i].eod));
        check($sformatf("vec%0d count", i), int'(count), int'(tbl[i].ecnt));
      end
      @(posedge clk); #1;
    end

    // Randomized traffic against the model, starting from a reset.
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    m_step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;
    for (int n = 0; n < 3000; n++) begin
      logic rst, fl, iv, ordy;
      logic [W-1:0] d;
      rst  = ($urandom_range(0, 199) == 0);
      fl   = ($urandom_range(0, 29) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      d    = W'($urandom);
      drive(rst, fl, iv, d, ordy);
      @(negedge clk);
      check("rnd in_ready", int'(in_ready), int'(m_in_ready(fl, ordy)));
      check("rnd out_valid", int'(out_valid), int'(m_out_valid(fl)));
      check("rnd out_data", int'(out_data), int'(m_last));
      check("rnd count", int'(count), m_data.size());
      m_step(rst, fl, iv, d, ordy);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
